// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencer for the 5-stage MIPS core. Owns the PC write enable,
//   IF/ID write/flush and the ID/EX bubble. It detects load-use hazards,
//   applies branch/jump flushes and freezes the whole pipe while data memory
//   is busy. A small FSM gates pipeline start, bounds memory waits with a
//   timeout, and keeps saturating stall/flush counters.
//
// Parameters
//   CNT_W     width of stall_cnt_o / flush_cnt_o (saturating)
//   MAX_WAIT  max consecutive mem_busy_i cycles before timeout (1..2^16-1)
//
// Ports
//   clk_i, rst_i (async, active-low)          clock / reset
//   start_i                                   pipeline run enable (level)
//   id_rs_i, id_rt_i, id_uses_rt_i            source regs of instruction in ID
//   ex_memread_i, ex_rt_i                     load in EX and its destination
//   branch_taken_i, jump_i                    control transfer resolved in ID
//   mem_busy_i                                data memory not ready
//   pc_write_o, ifid_write_o, ifid_flush_o    PC / IF-ID controls
//   idex_bubble_o, pipe_freeze_o              ID-EX bubble, back-end freeze
//   timeout_o                                 sticky memory-wait timeout
//   stall_cnt_o, flush_cnt_o                  saturating event counters
module hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  localparam logic [15:0]      MAX_WAIT_L = 16'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        timeout_nxt;
  logic        load_use;
  logic        stall_inc;
  logic        flush_inc;

  // $0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) ||
                     (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    timeout_nxt   = timeout_o;

    unique case (state)
      S_IDLE: begin
        idex_bubble_o = 1'b1;
        if (start_i) state_nxt = S_RUN;
      end

      S_RUN: begin
        if (mem_busy_i) begin
          pipe_freeze_o = 1'b1;
          state_nxt     = S_MEM_WAIT;
          wait_cnt_nxt  = 16'd1;
        end else begin
          // Load-use outranks a control transfer: the branch/jump stays in ID
          // and is taken on the following cycle once the hazard clears.
          if (load_use) begin
            idex_bubble_o = 1'b1;
          end else if (branch_taken_i || jump_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
          if (!start_i) state_nxt = S_IDLE;
        end
      end

      S_MEM_WAIT: begin
        pipe_freeze_o = 1'b1;
        if (!mem_busy_i) begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == MAX_WAIT_L) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end

      S_HALT: begin
        pipe_freeze_o = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign stall_inc = ((state == S_RUN) || (state == S_MEM_WAIT)) && !pc_write_o;
  assign flush_inc = ifid_flush_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      timeout_o   <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timeout_o <= timeout_nxt;
      if (stall_inc && (stall_cnt_o != CNT_MAX)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_inc && (flush_cnt_o != CNT_MAX)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_WAIT = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [4:0]       id_rs_i;
  logic [4:0]       id_rt_i;
  logic             id_uses_rt_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rt_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             mem_busy_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_freeze_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Output vector order: {pc_write, ifid_write, flush, bubble, freeze}
  localparam logic [4:0] O_IDLE  = 5'b00010;
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11100;
  localparam logic [4:0] O_FRZ   = 5'b00001;

  hazard_ctrl #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .mem_busy_i     (mem_busy_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [4:0] outs();
    return {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, check the combinational
  // outputs mid-cycle, then check counters and timeout after the next edge.
  task automatic apply(input string tag, input logic st, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic mr,
                       input logic [4:0] ert, input logic br, input logic j,
                       input logic busy, input logic [4:0] exp_o,
                       input int exp_s, input int exp_f, input logic exp_t);
    start_i        = st;
    id_rs_i        = rs;
    id_rt_i        = rt;
    id_uses_rt_i   = urt;
    ex_memread_i   = mr;
    ex_rt_i        = ert;
    branch_taken_i = br;
    jump_i         = j;
    mem_busy_i     = busy;
    @(negedge clk_i);
    check({tag, ".outs"}, 32'(outs()), 32'(exp_o));
    @(posedge clk_i);
    #1;
    check({tag, ".stall"}, 32'(stall_cnt_o), 32'(exp_s));
    check({tag, ".flush"}, 32'(flush_cnt_o), 32'(exp_f));
    check({tag, ".tmo"},   32'(timeout_o),   32'(exp_t));
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_uses_rt_i = 1'b0;
    ex_memread_i = 1'b0; ex_rt_i = '0; branch_taken_i = 1'b0; jump_i = 1'b0;
    mem_busy_i = 1'b0;

    @(negedge clk_i);
    check("rst.outs",  32'(outs()),      32'(O_IDLE));
    check("rst.stall", 32'(stall_cnt_o), 32'd0);
    check("rst.flush", 32'(flush_cnt_o), 32'd0);
    check("rst.tmo",   32'(timeout_o),   32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    //     tag          st rs     rt     urt mr ert    br j  busy exp_o   s  f  t
    apply("idle",       0, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 0,   O_IDLE, 0, 0, 0);
    apply("idle_busy",  0, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 1,   O_IDLE, 0, 0, 0);
    apply("start",      1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 1, 0,   O_IDLE, 0, 0, 0);
    apply("run",        1, 5'd1,  5'd4,  1,  0, 5'd0,  0, 0, 0,   O_NORM, 0, 0, 0);
    apply("lu_rs",      1, 5'd2,  5'd9,  0,  1, 5'd2,  0, 0, 0,   O_STALL,1, 0, 0);
    apply("ld_r0",      1, 5'd0,  5'd0,  1,  1, 5'd0,  0, 0, 0,   O_NORM, 1, 0, 0);
    apply("rt_unused",  1, 5'd3,  5'd5,  0,  1, 5'd5,  0, 0, 0,   O_NORM, 1, 0, 0);
    apply("lu_rt",      1, 5'd3,  5'd5,  1,  1, 5'd5,  0, 0, 0,   O_STALL,2, 0, 0);
    apply("no_match",   1, 5'd3,  5'd6,  1,  1, 5'd5,  0, 0, 0,   O_NORM, 2, 0, 0);
    apply("lu_br",      1, 5'd7,  5'd0,  0,  1, 5'd7,  1, 0, 0,   O_STALL,3, 0, 0);
    apply("br_after",   1, 5'd7,  5'd0,  0,  0, 5'd0,  1, 0, 0,   O_FLUSH,3, 1, 0);
    apply("jump",       1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 1, 0,   O_FLUSH,3, 2, 0);
    // Three busy cycles; the fourth (not busy) cycle is still spent in
    // MEM_WAIT, and start_i low there is ignored.
    apply("busy1",      1, 5'd2,  5'd0,  0,  1, 5'd2,  1, 0, 1,   O_FRZ,  4, 2, 0);
    apply("busy2",      0, 5'd0,  5'd0,  0,  0, 5'd0,  1, 0, 1,   O_FRZ,  5, 2, 0);
    apply("busy3",      1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 1, 1,   O_FRZ,  6, 2, 0);
    apply("wait_exit",  0, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 0,   O_FRZ,  7, 2, 0);
    apply("stop",       0, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 0,   O_NORM, 7, 2, 0);
    apply("idle2",      1, 5'd2,  5'd0,  0,  1, 5'd2,  0, 0, 0,   O_IDLE, 7, 2, 0);

    for (int i = 0; i < 10; i++)
      apply("lu_sat",   1, 5'd8,  5'd0,  0,  1, 5'd8,  0, 0, 0,   O_STALL,(7+i+1 > 15) ? 15 : 7+i+1, 2, 0);
    for (int i = 0; i < 16; i++)
      apply("j_sat",    1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 1, 0,   O_FLUSH,15, (2+i+1 > 15) ? 15 : 2+i+1, 0);

    // Timeout: wait count 1..4 over the first four busy cycles, the fifth
    // busy cycle finds it at MAX_WAIT and halts.
    for (int i = 0; i < 4; i++)
      apply("tmo_wait", 1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 1,   O_FRZ,  15, 15, 0);
    apply("tmo_hit",    1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 1,   O_FRZ,  15, 15, 1);
    apply("halt1",      1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 0,   O_FRZ,  15, 15, 1);
    apply("halt2",      1, 5'd0,  5'd0,  0,  0, 5'd0,  1, 1, 0,   O_FRZ,  15, 15, 1);

    // Asynchronous reset mid-cycle: outputs drop to IDLE values before any edge.
    #2;
    rst_i = 1'b0;
    #1;
    check("arst.outs",  32'(outs()),      32'(O_IDLE));
    check("arst.stall", 32'(stall_cnt_o), 32'd0);
    check("arst.flush", 32'(flush_cnt_o), 32'd0);
    check("arst.tmo",   32'(timeout_o),   32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    apply("post_rst",   1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 0,   O_IDLE, 0, 0, 0);
    apply("post_run",   1, 5'd0,  5'd0,  0,  0, 5'd0,  0, 0, 0,   O_NORM, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
